// File: rtl/booth_arith_pkg.sv
// Shared arithmetic-unit definitions used by the divider and the multiplier
// wrapper control.
//   state_e    : sequencer states (IDLE/ITER/FIX, 2-bit encoding)
//   cnt_width  : iteration-counter width for an x-bit operand, $clog2(x+1)
//   DEF_CNT_W  : counter width for the default 8-bit operand
package booth_arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic int cnt_width(input int x);
        return $clog2(x + 1);
    endfunction

    localparam int DEF_X     = 8;
    localparam int DEF_CNT_W = $clog2(DEF_X + 1);

endpackage

// File: rtl/booth_divider_if.sv
// Handshake and operand/result bundle for the signed divider.
//   start/a/b             : request side (master drives)
//   busy/done/q/rem/flags : result side (slave drives)
interface booth_divider_if #(
    parameter int x = 8,
    parameter int y = 4
);
    logic                start;
    logic signed [x-1:0] a;
    logic signed [y-1:0] b;
    logic                busy;
    logic                done;
    logic signed [x-1:0] q;
    logic signed [y-1:0] rem;
    logic                div0;
    logic                ovf;

    modport master (
        output start, a, b,
        input  busy, done, q, rem, div0, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, rem, div0, ovf
    );
endinterface

// File: rtl/booth_divider_step.sv
// div_step: one combinational restoring-division step.
//   prem_i      : partial remainder (y+1 bits, unsigned)
//   next_bit_i  : next dividend bit, MSB first
//   divisor_i   : |b| (y bits, unsigned)
//   prem_next_o : updated partial remainder
//   qbit_o      : 1 when the subtraction is kept
module div_step #(
    parameter int y = 4
) (
    input  logic [y:0]   prem_i,
    input  logic         next_bit_i,
    input  logic [y-1:0] divisor_i,
    output logic [y:0]   prem_next_o,
    output logic         qbit_o
);
    logic [y+1:0] shifted;
    logic [y+1:0] diff;

    always_comb begin
        shifted     = {prem_i, next_bit_i};
        diff        = shifted - {2'b00, divisor_i};
        // Top bit of the difference is the borrow: set means the trial
        // subtraction went negative and the shifted value is restored.
        qbit_o      = ~diff[y+1];
        prem_next_o = qbit_o ? diff[y:0] : shifted[y:0];
    end
endmodule

// File: rtl/booth_divider.sv
// booth_divider: sequential signed divider, q = a / b truncated toward zero,
// rem = a - q*b, fixed latency of x+1 cycles from the accepted start edge.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any operation in flight
//   bus : booth_divider_if slave (start/a/b in; busy/done/q/rem/div0/ovf out)
//
//   state | meaning
//   IDLE  | waiting for start; captures |a|, |b|, signs and special cases
//   ITER  | one restoring step per cycle, x steps total
//   FIX   | applies signs and special cases, registers the result, pulses done
module booth_divider
    import booth_arith_pkg::*;
#(
    parameter int x = 8,
    parameter int y = 4
) (
    input  logic            clk,
    input  logic            rst,
    booth_divider_if.slave  bus
);
    localparam int CW = cnt_width(x);
    localparam logic [x-1:0] A_MIN = {1'b1, {(x-1){1'b0}}};

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [x-1:0]  a_abs_q, a_abs_d;
    logic [y-1:0]  b_abs_q, b_abs_d;
    logic [y:0]    prem_q, prem_d;
    logic [x-1:0]  qsh_q, qsh_d;
    logic          sa_q, sa_d, sb_q, sb_d, bz_q, bz_d, ov_cap_q, ov_cap_d;
    logic          done_q, done_d, div0_q, div0_d, ovf_q, ovf_d;
    logic [x-1:0]  q_q, q_d;
    logic [y-1:0]  rem_q, rem_d;

    logic [y:0]    step_prem;
    logic          step_qbit;

    div_step #(.y(y)) u_step (
        .prem_i      (prem_q),
        .next_bit_i  (a_abs_q[x-1]),
        .divisor_i   (b_abs_q),
        .prem_next_o (step_prem),
        .qbit_o      (step_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_abs_q  <= '0;
            b_abs_q  <= '0;
            prem_q   <= '0;
            qsh_q    <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bz_q     <= 1'b0;
            ov_cap_q <= 1'b0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            q_q      <= '0;
            rem_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_abs_q  <= a_abs_d;
            b_abs_q  <= b_abs_d;
            prem_q   <= prem_d;
            qsh_q    <= qsh_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bz_q     <= bz_d;
            ov_cap_q <= ov_cap_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            q_q      <= q_d;
            rem_q    <= rem_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_abs_d  = a_abs_q;
        b_abs_d  = b_abs_q;
        prem_d   = prem_q;
        qsh_d    = qsh_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bz_d     = bz_q;
        ov_cap_d = ov_cap_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        q_d      = q_q;
        rem_d    = rem_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // x unsigned bits hold |-2^(x-1)| exactly.
                    a_abs_d  = bus.a[x-1] ? $unsigned(-bus.a) : $unsigned(bus.a);
                    b_abs_d  = bus.b[y-1] ? $unsigned(-bus.b) : $unsigned(bus.b);
                    sa_d     = bus.a[x-1];
                    sb_d     = bus.b[y-1];
                    bz_d     = (bus.b == '0);
                    ov_cap_d = ($unsigned(bus.a) == A_MIN) && (bus.b == '1);
                    prem_d   = '0;
                    qsh_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                prem_d  = step_prem;
                qsh_d   = {qsh_q[x-2:0], step_qbit};
                a_abs_d = {a_abs_q[x-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(x - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                done_d = 1'b1;
                div0_d = bz_q;
                ovf_d  = ov_cap_q;
                if (bz_q) begin
                    q_d   = '1;
                    rem_d = '0;
                end else begin
                    // Overflow case needs no override: |q| = 2^(x-1) wraps to
                    // -2^(x-1) and the remainder is already zero.
                    q_d   = (sa_q ^ sb_q) ? -qsh_q : qsh_q;
                    rem_d = sa_q ? -prem_q[y-1:0] : prem_q[y-1:0];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture cycle (ITER with count 0) is excluded so busy spans x cycles
    // and ends on the result edge.
    assign bus.busy = ((state_q == ST_ITER) && (cnt_q != '0)) || (state_q == ST_FIX);
    assign bus.done = done_q;
    assign bus.q    = q_q;
    assign bus.rem  = rem_q;
    assign bus.div0 = div0_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_booth_divider.sv
module tb_booth_divider;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    booth_divider_if #(.x(8), .y(4)) bus ();

    booth_divider #(.x(8), .y(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic (SV int '/' and '%' truncate toward zero).
    task automatic ref_div(input int av, input int bv, output logic [7:0] eq,
                           output logic [3:0] er, output logic ed0, output logic eov);
        int qi, ri;
        ed0 = 1'b0;
        eov = 1'b0;
        if (bv == 0) begin
            qi = -1; ri = 0; ed0 = 1'b1;
        end else if (av == -128 && bv == -1) begin
            qi = -128; ri = 0; eov = 1'b1;
        end else begin
            qi = av / bv; ri = av % bv;
        end
        eq = 8'(qi);
        er = 4'(ri);
    endtask

    // One operation; g1/g2 are loop cycles at which a stray start is pulsed.
    task automatic run_op(input int av, input int bv, input int g1, input int g2);
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed0, eov;
        int         cyc, busy_n;
        bit         seen;
        ref_div(av, bv, eq, er, ed0, eov);
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'(av); bus.b = 4'(bv);
        @(negedge clk);
        bus.start = 1'b0; bus.a = 8'($urandom); bus.b = 4'($urandom);
        cyc = 0; busy_n = 0; seen = 1'b0;
        while (cyc < 30) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            if (cyc == g1 || cyc == g2) begin
                bus.start = 1'b1; bus.a = 8'($urandom); bus.b = 4'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'd9);
        chk("busy_cycles", 32'(busy_n), 32'd8);
        chk("busy_with_done", 32'(bus.busy), 32'd0);
        chk("q", 32'($unsigned(bus.q)), 32'(eq));
        chk("rem", 32'($unsigned(bus.rem)), 32'(er));
        chk("div0", 32'(bus.div0), 32'(ed0));
        chk("ovf", 32'(bus.ovf), 32'(eov));
        @(negedge clk);
        chk("done_drop", 32'(bus.done), 32'd0);
        chk("q_hold", 32'($unsigned(bus.q)), 32'(eq));
    endtask

    initial begin : stim
        logic [7:0] eq;
        logic [3:0] er;
        logic       ed0, eov;
        int         cyc, ndone, t1, t2;
        bit         any_done;

        // Reset wins over start.
        rst = 1'b1; bus.start = 1'b1; bus.a = 8'd5; bus.b = 4'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_q", 32'($unsigned(bus.q)), 32'd0);
        chk("rst_rem", 32'($unsigned(bus.rem)), 32'd0);
        chk("rst_flags", 32'({bus.div0, bus.ovf}), 32'd0);
        @(negedge clk);
        chk("rst_no_accept", 32'(bus.busy), 32'd0);

        // Directed cases.
        run_op(100, 7, -1, -1);
        run_op(-100, 7, -1, -1);
        run_op(100, -7, -1, -1);
        run_op(-100, -7, -1, -1);
        run_op(37, 0, -1, -1);
        run_op(-128, -1, -1, -1);
        run_op(-128, 3, -1, -1);
        run_op(127, -8, -1, -1);
        run_op(-128, -8, -1, -1);
        run_op(0, 5, -1, -1);

        // Stray starts during iterations are ignored.
        run_op(77, 5, 2, 5);

        // Random operands.
        for (int i = 0; i < 25; i++) begin
            logic [7:0] ra;
            logic [3:0] rb;
            ra = 8'($urandom);
            rb = 4'($urandom);
            run_op(int'($signed(ra)), int'($signed(rb)), -1, -1);
        end

        // Reset mid-operation: no done, outputs cleared.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd20; bus.b = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) any_done = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(any_done), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_q", 32'($unsigned(bus.q)), 32'd0);
        chk("abort_rem", 32'($unsigned(bus.rem)), 32'd0);
        chk("abort_flags", 32'({bus.div0, bus.ovf}), 32'd0);
        run_op(9, 2, -1, -1);

        // Start held high through done: back-to-back operations.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'd50; bus.b = 4'd5;
        @(negedge clk);
        cyc = 0; ndone = 0; t1 = -1; t2 = -1;
        while (cyc <= 24) begin
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = cyc;
                    ref_div(50, 5, eq, er, ed0, eov);
                    chk("b2b_q1", 32'($unsigned(bus.q)), 32'(eq));
                    chk("b2b_rem1", 32'($unsigned(bus.rem)), 32'(er));
                    bus.a = -8'sd7; bus.b = 4'sd2;
                end else if (ndone == 2) begin
                    t2 = cyc;
                    ref_div(-7, 2, eq, er, ed0, eov);
                    chk("b2b_q2", 32'($unsigned(bus.q)), 32'(eq));
                    chk("b2b_rem2", 32'($unsigned(bus.rem)), 32'(er));
                    bus.start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        chk("b2b_done_count", 32'(ndone), 32'd2);
        chk("b2b_t1", 32'(t1), 32'd9);
        chk("b2b_t2", 32'(t2), 32'd19);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
